// File: rtl/debounce_scheduler_pkg.sv
// Shared types and helpers for the multi-channel debounce scheduler.
package debounce_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TIMING = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Bit 'pos' of the one-hot decode of 'idx'; callers loop over pos to build the vector.
    function automatic logic onehot(input int idx, input int pos);
        return idx == pos;
    endfunction

endpackage

// File: rtl/debounce_scheduler_if.sv
// Channel-side bundle of the debounce scheduler: raw inputs in, debounced state out.
interface debounce_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] sync_in;
    logic [NUM_CH-1:0] deb_out;
    logic [NUM_CH-1:0] deb_pulse;
    logic [CH_W-1:0]   grant_ch;
    logic              busy;

    modport master (
        output sync_in,
        input  deb_out, deb_pulse, grant_ch, busy
    );

    modport slave (
        input  sync_in,
        output deb_out, deb_pulse, grant_ch, busy
    );
endinterface

// File: rtl/debounce_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the channel after 'ptr' has highest priority.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_valid
);

    logic [NUM_CH-1:0] rot;
    int                off;
    int                sum;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        rot = '0;
        off = 0;
        sum = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            rot[j] = req[(int'(ptr) + 1 + j) % NUM_CH];
        end
        // Scan downward so the lowest rotated index, i.e. the nearest after ptr, wins.
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (rot[j]) off = j;
        end
        sum       = (int'(ptr) + 1 + off) % NUM_CH;
        gnt_idx   = CH_W'(sum);
        gnt_valid = |req;
    end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounce controller sharing one stability-window counter across NUM_CH synchronized inputs.
module debounce_scheduler
    import debounce_scheduler_pkg::*;
#(
    parameter int NUM_CH              = 4,
    parameter int counter_final_value = 99,
    localparam int CNT_W = $clog2(counter_final_value + 1),
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    debounce_scheduler_if.slave   bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] deb_q, deb_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              sample_q, sample_d;

    logic [NUM_CH-1:0] pending;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_valid;

    assign pending = bus.sync_in ^ deb_q;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (pending),
        .ptr       (rr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        deb_d    = deb_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        sample_d = sample_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d  = gnt_idx;
                    rr_d     = gnt_idx;
                    sample_d = bus.sync_in[gnt_idx];
                    cnt_d    = '0;
                    state_d  = TIMING;
                end
            end
            TIMING: begin
                // A mismatch takes precedence even on the terminal-count cycle.
                if (bus.sync_in[grant_q] != sample_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != CNT_W'(counter_final_value)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    deb_d[grant_q] = sample_q;
                    state_d        = COMMIT;
                end
            end
            COMMIT: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            deb_q    <= '0;
            grant_q  <= '0;
            rr_q     <= CH_W'(NUM_CH - 1);
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            deb_q    <= deb_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            bus.deb_pulse[i] = (state_q == COMMIT) && onehot(int'(grant_q), i);
        end
    end

    assign bus.deb_out  = deb_q;
    assign bus.grant_ch = grant_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed self-checking bench for debounce_scheduler with a 10-cycle window.
module tb_debounce_scheduler;

    localparam int NUM_CH = 4;
    localparam int FINAL  = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    debounce_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

    debounce_scheduler #(.NUM_CH(NUM_CH), .counter_final_value(FINAL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.sync_in = '0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.sync_in = 4'b1010;
        rst_n = 1'b0;
        step(3);
        chk_cnt++; if (bus.deb_out !== 4'b0000) $display("FAIL reset_deb_out: got %b want 0000", bus.deb_out); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.deb_pulse !== 4'b0000) $display("FAIL reset_pulse: got %b want 0000", bus.deb_pulse); else pass_cnt++;
        chk_cnt++; if (bus.grant_ch !== 2'd0) $display("FAIL reset_grant: got %0d want 0", bus.grant_ch); else pass_cnt++;
        rst_n = 1'b1;
        step(1);
        chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL reset_first_busy: got %b want 1", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.grant_ch !== 2'd1) $display("FAIL reset_first_grant: got %0d want 1", bus.grant_ch); else pass_cnt++;
    endtask

    task automatic test_clean_edge();
        apply_reset();
        bus.sync_in = 4'b0001;
        step(1);
        chk_cnt++; if (bus.grant_ch !== 2'd0 || bus.busy !== 1'b1) $display("FAIL clean_grant: got ch%0d busy %b want ch0 busy 1", bus.grant_ch, bus.busy); else pass_cnt++;
        step(9);
        chk_cnt++; if (bus.deb_out !== 4'b0000) $display("FAIL clean_early: got %b want 0000 at E10", bus.deb_out); else pass_cnt++;
        step(1);
        chk_cnt++; if (bus.deb_out !== 4'b0001) $display("FAIL clean_deb_out: got %b want 0001 at E11", bus.deb_out); else pass_cnt++;
        chk_cnt++; if (bus.deb_pulse !== 4'b0001) $display("FAIL clean_pulse: got %b want 0001", bus.deb_pulse); else pass_cnt++;
        step(1);
        chk_cnt++; if (bus.deb_pulse !== 4'b0000) $display("FAIL clean_pulse_width: got %b want 0000", bus.deb_pulse); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL clean_idle: got busy %b want 0 at E12", bus.busy); else pass_cnt++;
    endtask

    task automatic test_bounce();
        apply_reset();
        bus.sync_in = 4'b0010;
        step(5);
        bus.sync_in = 4'b0000;
        step(1);
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL bounce_abort: got busy %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.deb_out !== 4'b0000 || bus.deb_pulse !== 4'b0000) $display("FAIL bounce_no_commit: got out %b pulse %b want 0000 0000", bus.deb_out, bus.deb_pulse); else pass_cnt++;
        step(3);
        chk_cnt++; if (bus.busy !== 1'b0 || bus.deb_pulse !== 4'b0000) $display("FAIL bounce_settled: got busy %b pulse %b want 0 0000", bus.busy, bus.deb_pulse); else pass_cnt++;

        apply_reset();
        bus.sync_in = 4'b0010;
        step(10);
        chk_cnt++; if (bus.busy !== 1'b1 || bus.deb_out !== 4'b0000) $display("FAIL bounce_tc_pre: got busy %b out %b want 1 0000", bus.busy, bus.deb_out); else pass_cnt++;
        bus.sync_in = 4'b0000;
        step(1);
        chk_cnt++; if (bus.deb_out !== 4'b0000 || bus.deb_pulse !== 4'b0000) $display("FAIL bounce_tc_commit: got out %b pulse %b want 0000 0000", bus.deb_out, bus.deb_pulse); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL bounce_tc_idle: got busy %b want 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        bus.sync_in = 4'b0101;
        step(1);
        chk_cnt++; if (bus.grant_ch !== 2'd0) $display("FAIL simul_grant0: got %0d want 0", bus.grant_ch); else pass_cnt++;
        step(10);
        chk_cnt++; if (bus.deb_out !== 4'b0001 || bus.deb_pulse !== 4'b0001) $display("FAIL simul_commit0: got out %b pulse %b want 0001 0001", bus.deb_out, bus.deb_pulse); else pass_cnt++;
        step(1);
        chk_cnt++; if (bus.busy !== 1'b0 || bus.deb_pulse !== 4'b0000) $display("FAIL simul_gap: got busy %b pulse %b want 0 0000", bus.busy, bus.deb_pulse); else pass_cnt++;
        step(1);
        chk_cnt++; if (bus.grant_ch !== 2'd2 || bus.busy !== 1'b1) $display("FAIL simul_grant2: got ch%0d busy %b want ch2 busy 1", bus.grant_ch, bus.busy); else pass_cnt++;
        step(9);
        chk_cnt++; if (bus.deb_out !== 4'b0001) $display("FAIL simul_early2: got %b want 0001 at E22", bus.deb_out); else pass_cnt++;
        step(1);
        chk_cnt++; if (bus.deb_out !== 4'b0101 || bus.deb_pulse !== 4'b0100) $display("FAIL simul_commit2: got out %b pulse %b want 0101 0100", bus.deb_out, bus.deb_pulse); else pass_cnt++;
        step(1);
        chk_cnt++; if (bus.busy !== 1'b0 || bus.deb_pulse !== 4'b0000) $display("FAIL simul_done: got busy %b pulse %b want 0 0000", bus.busy, bus.deb_pulse); else pass_cnt++;
    endtask

    task automatic test_fairness();
        logic [1:0] order [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] want_pulse;
        apply_reset();
        // Grant and immediately abort ch1 so the pointer sits at 1.
        bus.sync_in = 4'b0010;
        step(1);
        bus.sync_in = 4'b0000;
        step(1);
        chk_cnt++; if (bus.busy !== 1'b0 || bus.grant_ch !== 2'd1) $display("FAIL fair_setup: got busy %b ch%0d want 0 ch1", bus.busy, bus.grant_ch); else pass_cnt++;
        bus.sync_in = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            want_pulse = 4'b0001 << order[k];
            step(1);
            chk_cnt++; if (bus.grant_ch !== order[k] || bus.busy !== 1'b1) $display("FAIL fair_grant%0d: got ch%0d busy %b want ch%0d busy 1", k, bus.grant_ch, bus.busy, order[k]); else pass_cnt++;
            step(10);
            chk_cnt++; if (bus.deb_pulse !== want_pulse) $display("FAIL fair_pulse%0d: got %b want %b", k, bus.deb_pulse, want_pulse); else pass_cnt++;
            step(1);
            chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL fair_idle%0d: got busy %b want 0", k, bus.busy); else pass_cnt++;
        end
        step(4);
        chk_cnt++; if (bus.deb_out !== 4'b1111 || bus.busy !== 1'b0) $display("FAIL fair_final: got out %b busy %b want 1111 0", bus.deb_out, bus.busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_timing();
        apply_reset();
        bus.sync_in = 4'b1000;
        step(1);
        chk_cnt++; if (bus.grant_ch !== 2'd3) $display("FAIL midrst_grant: got %0d want 3", bus.grant_ch); else pass_cnt++;
        step(5);
        rst_n = 1'b0;
        step(1);
        chk_cnt++; if (bus.deb_out !== 4'b0000 || bus.deb_pulse !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL midrst_state: got out %b pulse %b busy %b want 0000 0000 0", bus.deb_out, bus.deb_pulse, bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.grant_ch !== 2'd0) $display("FAIL midrst_grant_rst: got %0d want 0", bus.grant_ch); else pass_cnt++;
        rst_n = 1'b1;
        step(1);
        chk_cnt++; if (bus.grant_ch !== 2'd3 || bus.busy !== 1'b1) $display("FAIL midrst_repend: got ch%0d busy %b want ch3 busy 1", bus.grant_ch, bus.busy); else pass_cnt++;
        step(9);
        chk_cnt++; if (bus.deb_out !== 4'b0000) $display("FAIL midrst_early: got %b want 0000", bus.deb_out); else pass_cnt++;
        step(1);
        chk_cnt++; if (bus.deb_out !== 4'b1000 || bus.deb_pulse !== 4'b1000) $display("FAIL midrst_commit: got out %b pulse %b want 1000 1000", bus.deb_out, bus.deb_pulse); else pass_cnt++;
    endtask

    initial begin
        bus.sync_in = '0;
        test_reset();
        test_clean_edge();
        test_bounce();
        test_simultaneous();
        test_fairness();
        test_reset_mid_timing();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
Multi-channel debounce controller that shares a single stability-window counter across NUM_CH already-synchronized inputs. Channels whose input differs from their debounced output request the counter. A round-robin arbiter grants one channel at a time. The granted channel's output is committed only if its input holds stable for the full window. Sits after the per-channel synchronizers and replaces one timer per channel with one shared timer.

Parameters:
NUM_CH, 4, number of input channels (>=2)
counter_final_value, 99, terminal count; window = counter_final_value+1 cycles
CNT_W, $clog2(counter_final_value+1), counter width (derived, not overridden)
CH_W, $clog2(NUM_CH), channel index width (derived)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, synchronous, active-low
sync_in  input  NUM_CH  synchronized (not debounced) channel inputs
deb_out  output  NUM_CH  debounced channel outputs
deb_pulse  output  NUM_CH  one-hot, 1-cycle pulse on the cycle after a channel's deb_out changes
grant_ch  output  CH_W  index of channel currently owning the counter
busy  output  1  high when state != IDLE

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE, cnt=0, deb_out=0, grant_ch=0, rr_ptr=NUM_CH-1 (so ch0 has top priority first), sample=0. deb_pulse=0 and busy=0 follow from state.
- pending[i] = sync_in[i] ^ deb_out[i] (combinational). No sticky request storage.
- State IDLE: if |pending, round-robin pick g = first pending index searching rr_ptr+1, rr_ptr+2, ... with wrap mod NUM_CH. On that edge: grant_ch<=g, rr_ptr<=g, sample<=sync_in[g], cnt<=0, state<=TIMING. Otherwise stay in IDLE.
- State TIMING: each cycle compare sync_in[grant_ch] with sample.
  - Mismatch (abort): state<=IDLE, cnt<=0, deb_out unchanged, no pulse. An abort on the terminal-count cycle also aborts.
  - Match and cnt!=counter_final_value: cnt<=cnt+1.
  - Match and cnt==counter_final_value: deb_out[grant_ch]<=sample, state<=COMMIT.
- State COMMIT: deb_pulse = onehot(grant_ch). Decoded from state and grant_ch, so it is high for exactly this cycle. state<=IDLE. No arbitration occurs in COMMIT.
- Latency: sync_in[i] changes after edge E0 with no contention → deb_out[i] updates at edge E0+counter_final_value+2; deb_pulse[i] is high in the following cycle.
- Back-to-back service period: counter_final_value+3 cycles per channel (IDLE + window + COMMIT).
- Changes on non-granted channels during TIMING: no effect on the current window. They are arbitrated at the next IDLE. If a non-granted channel bounces back to match deb_out, it is never serviced.
- Abort fairness: rr_ptr has already advanced to g, so the aborted channel drops to lowest priority.
- Reset mid-TIMING or mid-COMMIT: everything returns to reset values in one edge. No pulse is emitted. Channels with sync_in=1 re-pend after reset.
- cnt never exceeds counter_final_value. No wrap.

Decomposition:
- Shared package: state enum {IDLE, TIMING, COMMIT} (2-bit); a function computing onehot(CH_W→NUM_CH).
- One natural sub-module: rr_arbiter.
  - Parameter NUM_CH.
  - Inputs: req[NUM_CH], ptr[CH_W].
  - Outputs: gnt_idx[CH_W], gnt_valid.
  - Purely combinational rotate-priority-rotate-back implementation.
- The counter, sample register and FSM stay in debounce_scheduler.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with sync_in=4'b1010 → deb_out=0, busy=0, deb_pulse=0. After release, ch1 is granted first.
- Clean edge (counter_final_value=9): sync_in[0] 0→1 after E0, held → deb_out[0]=1 at E11, deb_pulse=4'b0001 for exactly one cycle, busy low again at E12.
- Bounce: sync_in[1] high for 5 cycles then low → abort at the mismatch cycle, state IDLE, deb_out[1]=0, no pulse. Bounce exactly at cnt=9 → also no commit.
- Simultaneous requests: ch0 and ch2 rise after E0 and hold → deb_out[0] at E11, deb_out[2] at E23, pulses 12 cycles apart.
- Fairness: all four channels toggle and hold, with rr_ptr=1 from prior activity → grant order 2, 3, 0, 1, and each channel commits exactly once.
- Reset mid-TIMING: assert rst_n=0 at cnt=5 on ch3 with sync_in[3]=1 → deb_out=0, no pulse. After release, ch3 re-pends and commits counter_final_value+2 cycles later.
